// File: rtl/coef_addr_pkg.sv
// Shared types and helpers for the coefficient-ROM address sequencer.
// Optional feature macro: COEF_ADDR_AUTORESTART_EN (see coef_addr_gen.sv).
package coef_addr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cag_state_t;

  typedef enum logic {
    FWD = 1'b0,
    REV = 1'b1
  } cag_mode_t;

  // Number of beats in one sweep: ceil(depth/step)
  function automatic int cag_beats(input int depth, input int step);
    return (depth + step - 1) / step;
  endfunction

endpackage

// File: rtl/coef_tap_cnt.sv
// Bounded up/down stride counter producing the tap index of a sweep.
// Optional feature macro: none (COEF_ADDR_AUTORESTART_EN lives in the top).
module coef_tap_cnt
  import coef_addr_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int STEP  = 1,
  parameter int TAP_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dir,
  input  logic             advance,
  output logic [TAP_W-1:0] tap,
  output logic             is_last
);

  localparam int N = cag_beats(DEPTH, STEP);
  localparam logic [TAP_W:0] LAST_TAP = (TAP_W+1)'((N - 1) * STEP);
  localparam logic [TAP_W:0] STP      = (TAP_W+1)'(STEP);
  localparam logic [TAP_W:0] BOUND    = (TAP_W+1)'(DEPTH);

  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W:0]   nxt;
  logic             dir_q, dir_d;
  logic             last_q, last_d;

  always_comb begin
    tap_d  = tap_q;
    dir_d  = dir_q;
    last_d = last_q;
    nxt    = '0;
    if (load) begin
      dir_d  = dir;
      nxt    = dir ? LAST_TAP : '0;
      tap_d  = nxt[TAP_W-1:0];
      last_d = (N == 1);
    end else if (advance) begin
      // One extra bit keeps tap+2*STEP from wrapping before the bound test
      if (dir_q) begin
        nxt    = {1'b0, tap_q} - STP;
        last_d = (nxt < STP);
      end else begin
        nxt    = {1'b0, tap_q} + STP;
        last_d = ((nxt + STP) >= BOUND);
      end
      tap_d = nxt[TAP_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q  <= '0;
      dir_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      tap_q  <= tap_d;
      dir_q  <= dir_d;
      last_q <= last_d;
    end
  end

  assign tap     = tap_q;
  assign is_last = last_q;

endmodule

// File: rtl/coef_addr_gen.sv
// Coefficient-ROM address sequencer: one stride sweep per start, FWD/REV.
// Define COEF_ADDR_AUTORESTART_EN to chain sweeps automatically.
module coef_addr_gen
  import coef_addr_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int STEP   = 1,
  parameter int NUM_CH = 1,
  parameter int TAP_W  = $clog2(DEPTH),
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  abort,
  output logic [CH_W+TAP_W-1:0] addr,
  output logic                  addr_vld,
  input  logic                  addr_rdy,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

  cag_state_t       state_q, state_d;
  cag_mode_t        mode_q, mode_d;
  logic [CH_W-1:0]  ch_q, ch_d, ch_lat;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             load, advance, dir;
  logic             fire;
  logic [TAP_W-1:0] tap;
  logic             cnt_last;

  assign ch_lat = (ch_sel > CH_MAX) ? CH_MAX : ch_sel;
  assign fire   = vld_q & addr_rdy;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ch_d    = ch_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    dir     = (mode_q == REV);
    unique case (state_q)
      IDLE: begin
        dir = mode;
        if (start && !abort) begin
          state_d = RUN;
          mode_d  = cag_mode_t'(mode);
          ch_d    = ch_lat;
          vld_d   = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else if (fire) begin
          if (cnt_last) begin
            done_d = 1'b1;
`ifdef COEF_ADDR_AUTORESTART_EN
            ch_d   = ch_lat;
            load   = 1'b1;
`else
            state_d = IDLE;
            vld_d   = 1'b0;
`endif
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= FWD;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  coef_tap_cnt #(
    .DEPTH (DEPTH),
    .STEP  (STEP),
    .TAP_W (TAP_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .dir     (dir),
    .advance (advance),
    .tap     (tap),
    .is_last (cnt_last)
  );

  assign addr     = {ch_q, tap};
  assign addr_vld = vld_q;
  assign last     = cnt_last & vld_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_coef_addr_gen.sv
// Directed bench for coef_addr_gen across four parameter sets.
// Covers COEF_ADDR_AUTORESTART_EN when that macro is defined.
module tb_coef_addr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] st  = '0;
  logic [3:0] md  = '0;
  logic [3:0] ab  = '0;
  logic [3:0] rdy = '0;
  logic [3:0][1:0] cs = '0;
  logic [3:0] vl, la, bz, dn;
  logic [5:0] a0, a1;
  logic [3:0] a2;
  logic [4:0] a3;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coef_addr_gen #(.DEPTH(32), .STEP(1), .NUM_CH(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .mode(md[0]),
    .ch_sel(cs[0][0]), .abort(ab[0]), .addr(a0), .addr_vld(vl[0]),
    .addr_rdy(rdy[0]), .last(la[0]), .busy(bz[0]), .done(dn[0]));

  coef_addr_gen #(.DEPTH(32), .STEP(2), .NUM_CH(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .mode(md[1]),
    .ch_sel(cs[1][0]), .abort(ab[1]), .addr(a1), .addr_vld(vl[1]),
    .addr_rdy(rdy[1]), .last(la[1]), .busy(bz[1]), .done(dn[1]));

  coef_addr_gen #(.DEPTH(7), .STEP(3), .NUM_CH(1)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .mode(md[2]),
    .ch_sel(cs[2][0]), .abort(ab[2]), .addr(a2), .addr_vld(vl[2]),
    .addr_rdy(rdy[2]), .last(la[2]), .busy(bz[2]), .done(dn[2]));

  coef_addr_gen #(.DEPTH(8), .STEP(1), .NUM_CH(3)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .mode(md[3]),
    .ch_sel(cs[3]), .abort(ab[3]), .addr(a3), .addr_vld(vl[3]),
    .addr_rdy(rdy[3]), .last(la[3]), .busy(bz[3]), .done(dn[3]));

  function automatic int get_addr(input int i);
    case (i)
      0:       return int'(a0);
      1:       return int'(a1);
      2:       return int'(a2);
      default: return int'(a3);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int inst;
    bit md;
    int ch;
    int first;
    int delta;
    int beats;
    int base;
    bit stall;
  } vec_t;

`ifndef COEF_ADDR_AUTORESTART_EN
  task automatic run_sweep(input vec_t v);
    int k = 0;
    int cyc = 0;
    int exp_a;
    int last_a = -1;
    int hold_a = 0;
    int hold_l = 0;
    bit hold = 1'b0;
    md[v.inst] = v.md;
    cs[v.inst] = 2'(v.ch);
    st[v.inst] = 1'b1;
    @(negedge clk);
    st[v.inst] = 1'b0;
    chk("first_vld", int'(vl[v.inst]), 1);
    chk("busy_rise", int'(bz[v.inst]), 1);
    while (k < v.beats && cyc < 400) begin
      if (hold) begin
        chk("stall_addr", get_addr(v.inst), hold_a);
        chk("stall_last", int'(la[v.inst]), hold_l);
      end
      if (!v.stall) chk("no_gap", int'(vl[v.inst]), 1);
      rdy[v.inst] = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = 1'b0;
      if (vl[v.inst]) begin
        if (rdy[v.inst]) begin
          exp_a = v.base + v.first + k * v.delta;
          chk("addr", get_addr(v.inst), exp_a);
          chk("last", int'(la[v.inst]), int'(k == v.beats - 1));
          last_a = exp_a;
          k++;
        end else begin
          hold   = 1'b1;
          hold_a = get_addr(v.inst);
          hold_l = int'(la[v.inst]);
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("beat_count", k, v.beats);
    chk("done_pulse", int'(dn[v.inst]), 1);
    chk("vld_off", int'(vl[v.inst]), 0);
    chk("busy_off", int'(bz[v.inst]), 0);
    chk("last_off", int'(la[v.inst]), 0);
    chk("addr_hold", get_addr(v.inst), last_a);
    rdy[v.inst] = 1'b0;
    @(negedge clk);
    chk("done_1cyc", int'(dn[v.inst]), 0);
  endtask
`endif

  initial begin
    vec_t tbl[8];
    int dcnt;
    int seq[3];
    seq[0] = 0;
    seq[1] = 3;
    seq[2] = 6;

    #2;
    for (int i = 0; i < 4; i++) begin
      chk("rst_vld", int'(vl[i]), 0);
      chk("rst_busy", int'(bz[i]), 0);
      chk("rst_done", int'(dn[i]), 0);
      chk("rst_last", int'(la[i]), 0);
      chk("rst_addr", get_addr(i), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifndef COEF_ADDR_AUTORESTART_EN
    tbl[0] = '{0, 1'b0, 0, 0, 1, 32, 0, 1'b0};
    tbl[1] = '{1, 1'b1, 0, 30, -2, 16, 0, 1'b0};
    tbl[2] = '{2, 1'b0, 0, 0, 3, 3, 0, 1'b1};
    tbl[3] = '{2, 1'b1, 0, 6, -3, 3, 0, 1'b1};
    tbl[4] = '{3, 1'b0, 2, 0, 1, 8, 16, 1'b1};
    tbl[5] = '{3, 1'b1, 3, 7, -1, 8, 16, 1'b0};
    tbl[6] = '{3, 1'b0, 1, 0, 1, 8, 8, 1'b0};
    tbl[7] = '{1, 1'b0, 0, 0, 2, 16, 0, 1'b1};
    for (int t = 0; t < 8; t++) run_sweep(tbl[t]);

    // start during RUN ignored, then restart in the done cycle
    md[2] = 1'b0;
    st[2] = 1'b1;
    rdy[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    chk("rs_a0", int'(a2), 0);
    @(negedge clk);
    chk("rs_a1", int'(a2), 3);
    st[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    chk("rs_a2", int'(a2), 6);
    chk("rs_last", int'(la[2]), 1);
    @(negedge clk);
    chk("rs_done", int'(dn[2]), 1);
    chk("rs_vld0", int'(vl[2]), 0);
    st[2] = 1'b1;
    md[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    chk("rs2_vld", int'(vl[2]), 1);
    chk("rs2_busy", int'(bz[2]), 1);
    chk("rs2_done0", int'(dn[2]), 0);
    chk("rs2_a0", int'(a2), 6);
    @(negedge clk);
    chk("rs2_a1", int'(a2), 3);
    @(negedge clk);
    chk("rs2_a2", int'(a2), 0);
    chk("rs2_last", int'(la[2]), 1);
    @(negedge clk);
    chk("rs2_done", int'(dn[2]), 1);
    rdy[2] = 1'b0;
    @(negedge clk);
`else
    // three chained sweeps with no vld gap, one done per completed sweep
    md[2] = 1'b0;
    st[2] = 1'b1;
    rdy[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      chk("ar_vld", int'(vl[2]), 1);
      chk("ar_busy", int'(bz[2]), 1);
      chk("ar_addr", int'(a2), seq[k % 3]);
      chk("ar_last", int'(la[2]), int'(k % 3 == 2));
      if (dn[2]) dcnt++;
      @(negedge clk);
    end
    chk("ar_done_cnt", dcnt, 3);
    ab[2] = 1'b1;
    @(negedge clk);
    ab[2] = 1'b0;
    rdy[2] = 1'b0;
    chk("ar_abort_vld", int'(vl[2]), 0);
    chk("ar_abort_busy", int'(bz[2]), 0);
    foreach (tbl[t]) tbl[t] = '{0, 1'b0, 0, 0, 0, 0, 0, 1'b0};
`endif

    // abort at beat 5 with a simultaneous handshake
    md[0] = 1'b0;
    st[0] = 1'b1;
    rdy[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("ab_addr5", int'(a0), 5);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("ab_vld", int'(vl[0]), 0);
    chk("ab_busy", int'(bz[0]), 0);
    chk("ab_done", int'(dn[0]), 0);
    for (int k = 0; k < 4; k++) begin
      chk("ab_no_done", int'(dn[0]), 0);
      @(negedge clk);
    end

    // abort together with start in IDLE
    ab[0] = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    st[0] = 1'b0;
    chk("abst_vld", int'(vl[0]), 0);
    chk("abst_busy", int'(bz[0]), 0);

    // async reset mid-sweep
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_vld", int'(vl[0]), 0);
    chk("mrst_busy", int'(bz[0]), 0);
    chk("mrst_last", int'(la[0]), 0);
    chk("mrst_done", int'(dn[0]), 0);
    chk("mrst_addr", int'(a0), 0);
    @(negedge clk);
    rst = 1'b0;
    rdy[0] = 1'b0;
    @(negedge clk);
    chk("mrst_idle", int'(bz[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
